// File: rtl/psum_mux_pkg.sv
// psum_mux shared definitions.
// Default widths and FSM state encodings.
package psum_mux_pkg;

    localparam int DW_NUM_MAC         = 3;
    localparam int DW_PSUM_WIDTH      = 24;
    localparam int DW_PSUM_ADDR_WIDTH = 5;
    localparam int DW_DEPTH           = 14;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/psum_mux_rr_arbiter.sv
// Round-robin arbiter for the psum lanes.
// Grant is combinational; pointer moves past the winner.
module psum_mux_rr_arbiter
    import psum_mux_pkg::*;
#(
    parameter int N = DW_NUM_MAC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic [PW:0]   j;
    logic          found;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        gnt_o = '0;
        win   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, ptr_q} + (PW+1)'(k);
            if (j >= (PW+1)'(N)) begin
                j = j - (PW+1)'(N);
            end
            if (!found && req_i[j[PW-1:0]]) begin
                found = 1'b1;
                win   = j[PW-1:0];
                gnt_o[j[PW-1:0]] = 1'b1;
            end
        end
        ptr_d = (win == PW'(N-1)) ? '0 : win + 1'b1;
    end

    // Pointer advances only when a grant is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en_i && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/psum_mux.sv
// MAC-to-MUX psum responder: arbitrate, accumulate, drain.
// Row buffer is flushed out with valid/ready on request.
module psum_mux
    import psum_mux_pkg::*;
#(
    parameter int NUM_MAC         = DW_NUM_MAC,
    parameter int PSUM_WIDTH      = DW_PSUM_WIDTH,
    parameter int PSUM_ADDR_WIDTH = DW_PSUM_ADDR_WIDTH,
    parameter int DEPTH           = DW_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MAC-1:0]                 MACMUX_Val,
    input  logic [NUM_MAC*PSUM_ADDR_WIDTH-1:0] MACMUX_Addr,
    input  logic [NUM_MAC*PSUM_WIDTH-1:0]      MACMUX_Psum,
    input  logic [NUM_MAC-1:0]                 MACMUX_Empty,
    output logic [NUM_MAC-1:0]                 MUXMAC_Rdy,
    input  logic                               I_Flush,
    output logic                               O_Val,
    output logic [$clog2(DEPTH)-1:0]           O_Addr,
    output logic [PSUM_WIDTH-1:0]              O_Psum,
    input  logic                               I_Rdy,
    output logic                               O_Done,
    output logic                               O_Busy
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e                       state_q;
    logic [IDX_W-1:0]             idx_q;
    logic                         val_q;
    logic                         done_q;
    logic [NUM_MAC-1:0]           rdy_q;
    logic [NUM_MAC-1:0]           req;
    logic [NUM_MAC-1:0]           gnt;
    logic                         acc_en;
    logic                         cap_vld_q;
    logic [PSUM_ADDR_WIDTH-1:0]   cap_addr_q;
    logic [PSUM_WIDTH-1:0]        cap_psum_q;
    logic [PSUM_ADDR_WIDTH-1:0]   sel_addr;
    logic [PSUM_WIDTH-1:0]        sel_psum;
    logic                         flush_go;
    logic                         beat;
    logic                         last;
    logic                         acc_hit;
    logic [IDX_W-1:0]             acc_idx;
    logic [PSUM_WIDTH-1:0]        row_q [DEPTH];
    logic [PSUM_WIDTH-1:0]        row_d [DEPTH];

    assign acc_en   = (state_q == ST_ACC);
    assign req      = acc_en ? (MACMUX_Val & ~rdy_q) : '0;
    assign flush_go = acc_en & I_Flush & (&MACMUX_Empty)
                    & ~(|MACMUX_Val) & ~cap_vld_q;
    assign beat     = val_q & I_Rdy;
    assign last     = beat & (idx_q == IDX_W'(DEPTH-1));
    assign acc_hit  = cap_vld_q && (cap_addr_q != '0)
                    && (cap_addr_q <= PSUM_ADDR_WIDTH'(DEPTH));
    assign acc_idx  = IDX_W'(cap_addr_q - 1'b1);

    psum_mux_rr_arbiter #(
        .N     (NUM_MAC)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .en_i  (acc_en),
        .gnt_o (gnt)
    );

    // Select the winning lane's address and psum.
    always_comb begin
        sel_addr = '0;
        sel_psum = '0;
        for (int i = 0; i < NUM_MAC; i++) begin
            if (gnt[i]) begin
                sel_addr = MACMUX_Addr[i*PSUM_ADDR_WIDTH +: PSUM_ADDR_WIDTH];
                sel_psum = MACMUX_Psum[i*PSUM_WIDTH +: PSUM_WIDTH];
            end
        end
    end

    // Ready pulse and capture stage, one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= '0;
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
            cap_psum_q <= '0;
        end else begin
            rdy_q     <= gnt;
            cap_vld_q <= |gnt;
            if (|gnt) begin
                cap_addr_q <= sel_addr;
                cap_psum_q <= sel_psum;
            end
        end
    end

    // Next row contents: accumulate a capture, clear a drained entry.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            row_d[e] = row_q[e];
        end
        if (acc_hit) begin
            row_d[acc_idx] = row_q[acc_idx] + cap_psum_q;
        end
        if (beat) begin
            row_d[idx_q] = '0;
        end
    end

    // Row buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                row_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                row_q[e] <= row_d[e];
            end
        end
    end

    // Control FSM: accumulate, drain the row, signal completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            idx_q   <= '0;
            val_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_ACC: begin
                    if (flush_go) begin
                        state_q <= ST_DRAIN;
                        val_q   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (last) begin
                        state_q <= ST_DONE;
                        val_q   <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                    end else if (beat) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_ACC;
                    idx_q   <= '0;
                end
                default: begin
                    state_q <= ST_ACC;
                    val_q   <= 1'b0;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign MUXMAC_Rdy = rdy_q;
    assign O_Val      = val_q;
    assign O_Addr     = idx_q;
    assign O_Psum     = row_q[idx_q];
    assign O_Done     = done_q;
    assign O_Busy     = ~acc_en | cap_vld_q;

endmodule

// File: tb/tb_psum_mux.sv
// Directed testbench for psum_mux.
// Hand-computed expectations for arbitration, accumulate and drain.
module tb_psum_mux;
    import psum_mux_pkg::*;

    localparam int NM    = 3;
    localparam int PW    = 24;
    localparam int AW    = 5;
    localparam int DEPTH = 14;

    logic                 clk;
    logic                 rst_n;
    logic [NM-1:0]        val;
    logic [NM-1:0][AW-1:0] addr_v;
    logic [NM-1:0][PW-1:0] psum_v;
    logic [NM-1:0]        empty;
    logic [NM-1:0]        MUXMAC_Rdy;
    logic                 I_Flush;
    logic                 O_Val;
    logic [3:0]           O_Addr;
    logic [PW-1:0]        O_Psum;
    logic                 I_Rdy;
    logic                 O_Done;
    logic                 O_Busy;

    int n_tests = 0;
    int n_fail  = 0;
    int req_c [NM] = '{0, 0, 0};
    int ack_c [NM] = '{0, 0, 0};
    logic [PW-1:0] exp_row [DEPTH];

    psum_mux dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MACMUX_Val   (val),
        .MACMUX_Addr  (addr_v),
        .MACMUX_Psum  (psum_v),
        .MACMUX_Empty (empty),
        .MUXMAC_Rdy   (MUXMAC_Rdy),
        .I_Flush      (I_Flush),
        .O_Val        (O_Val),
        .O_Addr       (O_Addr),
        .O_Psum       (O_Psum),
        .I_Rdy        (I_Rdy),
        .O_Done       (O_Done),
        .O_Busy       (O_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane model: valid while a request is outstanding, dropped under ready.
    always_comb begin
        for (int i = 0; i < NM; i++) begin
            val[i] = (req_c[i] != ack_c[i]) && !MUXMAC_Rdy[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NM; i++) begin
            if (MUXMAC_Rdy[i]) ack_c[i] <= ack_c[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic check_row(input string tag);
        for (int e = 0; e < DEPTH; e++) begin
            chk(tag, dut.row_q[e], exp_row[e]);
        end
    endtask

    task automatic send_wait(input int l, input logic [AW-1:0] a,
                             input logic [PW-1:0] p);
        int n = 0;
        @(negedge clk);
        addr_v[l] = a;
        psum_v[l] = p;
        req_c[l]  = req_c[l] + 1;
        while (req_c[l] != ack_c[l] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("send_ack", ack_c[l], req_c[l]);
        repeat (2) @(negedge clk);
    endtask

    task automatic drain(input bit tog, input int lat);
        int idx = 0;
        int n   = 0;
        bit r   = 1'b0;
        while (!O_Val && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_lat", n, lat);
        n = 0;
        while (idx < DEPTH && n < 80) begin
            chk("drain_val", O_Val, 1);
            chk("drain_addr", O_Addr, idx);
            chk("drain_psum", O_Psum, exp_row[idx]);
            chk("drain_hold_rdy", MUXMAC_Rdy, 0);
            r = tog ? ~r : 1'b1;
            I_Rdy = r;
            if (r) idx++;
            @(negedge clk);
            n++;
        end
        chk("drain_count", idx, DEPTH);
        chk("done_pulse", O_Done, 1);
        chk("done_val", O_Val, 0);
        I_Rdy   = 1'b0;
        I_Flush = 1'b0;
        @(negedge clk);
        chk("done_once", O_Done, 0);
        chk("post_busy", O_Busy, 0);
        chk("post_rdy", MUXMAC_Rdy, 0);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        I_Flush = 1'b0;
        I_Rdy   = 1'b0;
        empty   = '1;
        addr_v  = '0;
        psum_v  = '0;
        for (int e = 0; e < DEPTH; e++) exp_row[e] = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", MUXMAC_Rdy, 0);
        chk("rst_val", O_Val, 0);
        chk("rst_done", O_Done, 0);
        chk("rst_busy", O_Busy, 0);
        chk("rst_addr", O_Addr, 0);
        chk("rst_psum", O_Psum, 0);
        rst_n = 1'b1;

        // All three lanes at once, same entry.
        @(negedge clk);
        for (int i = 0; i < NM; i++) addr_v[i] = 5'd5;
        psum_v[0] = 24'd10;
        psum_v[1] = 24'hFFFFFC;
        psum_v[2] = 24'd7;
        for (int i = 0; i < NM; i++) req_c[i] = req_c[i] + 1;
        @(negedge clk); chk("rr_0", MUXMAC_Rdy, 3'b001);
        @(negedge clk); chk("rr_1", MUXMAC_Rdy, 3'b010);
        @(negedge clk); chk("rr_2", MUXMAC_Rdy, 3'b100);
        @(negedge clk); chk("rr_idle", MUXMAC_Rdy, 0);
        chk("rr_sum", dut.row_q[4], 24'd13);
        exp_row[4] = 24'd13;

        // Single lane, latency and pulse width.
        @(negedge clk);
        addr_v[0] = 5'd3;
        psum_v[0] = 24'd100;
        req_c[0]  = req_c[0] + 1;
        @(negedge clk);
        chk("single_rdy", MUXMAC_Rdy, 3'b001);
        chk("single_busy", O_Busy, 1);
        chk("single_pre", dut.row_q[2], 0);
        @(negedge clk);
        chk("single_width", MUXMAC_Rdy, 0);
        chk("single_acc", dut.row_q[2], 24'd100);
        chk("single_idle", O_Busy, 0);
        exp_row[2] = 24'd100;

        // Back-to-back hits on one entry.
        @(negedge clk);
        addr_v[1] = 5'd1;
        psum_v[1] = 24'd5;
        req_c[1]  = req_c[1] + 1;
        @(negedge clk);
        chk("b2b_r1", MUXMAC_Rdy, 3'b010);
        addr_v[2] = 5'd1;
        psum_v[2] = 24'd6;
        req_c[2]  = req_c[2] + 1;
        @(negedge clk); chk("b2b_r2", MUXMAC_Rdy, 3'b100);
        @(negedge clk); chk("b2b_sum", dut.row_q[0], 24'd11);
        exp_row[0] = 24'd11;

        // Out-of-range addresses are acked and dropped.
        @(negedge clk);
        addr_v[0] = 5'd0;
        psum_v[0] = 24'd99;
        addr_v[1] = 5'd15;
        psum_v[1] = 24'd77;
        req_c[0]  = req_c[0] + 1;
        req_c[1]  = req_c[1] + 1;
        @(negedge clk); chk("oor_r0", MUXMAC_Rdy, 3'b001);
        @(negedge clk); chk("oor_r1", MUXMAC_Rdy, 3'b010);
        repeat (2) @(negedge clk);
        check_row("oor_row");

        // Wrap-around add and a few more entries.
        send_wait(2, 5'd14, 24'h7FFFFF);
        send_wait(2, 5'd14, 24'h000001);
        send_wait(0, 5'd7, 24'hFFFFCE);
        send_wait(1, 5'd10, 24'h123456);
        chk("wrap", dut.row_q[13], 24'h800000);
        exp_row[13] = 24'h800000;
        exp_row[6]  = 24'hFFFFCE;
        exp_row[9]  = 24'h123456;
        check_row("fill_row");

        // Flush held off by a busy lane, then drained with stalls.
        @(negedge clk);
        I_Flush = 1'b1;
        empty   = 3'b011;
        repeat (3) begin
            @(negedge clk);
            chk("flush_hold_val", O_Val, 0);
            chk("flush_hold_busy", O_Busy, 0);
        end
        empty = 3'b111;
        drain(1'b1, 1);
        for (int e = 0; e < DEPTH; e++) exp_row[e] = '0;
        check_row("cleared_row");

        // Readback of a cleared row; lane held off during drain.
        I_Flush = 1'b1;
        @(negedge clk);
        chk("drain2_val", O_Val, 1);
        addr_v[0] = 5'd2;
        psum_v[0] = 24'd9;
        req_c[0]  = req_c[0] + 1;
        drain(1'b0, 0);
        @(negedge clk);
        chk("resume_rdy", MUXMAC_Rdy, 3'b001);
        repeat (2) @(negedge clk);
        exp_row[1] = 24'd9;
        check_row("resume_row");

        // Reset in the middle of a drain.
        I_Flush = 1'b1;
        I_Rdy   = 1'b1;
        n = 0;
        while (!(O_Val && O_Addr == 4'd6) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", O_Addr, 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_val", O_Val, 0);
        chk("mid_rst_addr", O_Addr, 0);
        chk("mid_rst_psum", O_Psum, 0);
        chk("mid_rst_busy", O_Busy, 0);
        chk("mid_rst_done", O_Done, 0);
        chk("mid_rst_rdy", MUXMAC_Rdy, 0);
        I_Flush = 1'b0;
        I_Rdy   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_val", O_Val, 0);
        chk("rel_busy", O_Busy, 0);
        for (int e = 0; e < DEPTH; e++) exp_row[e] = '0;
        check_row("rst_row");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_mux.md
Name: psum_mux

Overview:
- Responder end of the MAC→MUX partial-sum handshake.
- Collects psums from NUM_MAC MAC lanes through a round-robin arbiter and returns a one-cycle ready pulse to the winning lane.
- Accumulates each psum into a DEPTH-entry row buffer indexed by the MAC's psum address.
- On a flush request, once all lanes are empty, streams the row out with valid/ready and clears the buffer.

Parameters:
- NUM_MAC, 3, number of MAC lanes served.
- PSUM_WIDTH, 24, psum/accumulator width (two's complement).
- PSUM_ADDR_WIDTH, 5, MAC psum address width.
- DEPTH, 14, row buffer entries; valid MAC addresses are 1..DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- MACMUX_Val  in  NUM_MAC  per-lane psum valid; the lane drops it combinationally while its ready is high.
- MACMUX_Addr  in  NUM_MAC*PSUM_ADDR_WIDTH  per-lane psum address, lane i at bits [i*PSUM_ADDR_WIDTH +: PSUM_ADDR_WIDTH].
- MACMUX_Psum  in  NUM_MAC*PSUM_WIDTH  per-lane psum, same packing.
- MACMUX_Empty  in  NUM_MAC  per-lane idle flag.
- MUXMAC_Rdy  out  NUM_MAC  one-hot, one-cycle accept pulse.
- I_Flush  in  1  request to drain the row (level; held until O_Done).
- O_Val  out  1  drain data valid.
- O_Addr  out  $clog2(DEPTH)  drain entry index.
- O_Psum  out  PSUM_WIDTH  drain data.
- I_Rdy  in  1  downstream ready.
- O_Done  out  1  one-cycle pulse after the last drain beat.
- O_Busy  out  1  high while not in ACC, or while a capture/accumulate is in flight.

Behaviour:
- Reset: all outputs 0; state ACC; buffer entries 0; round-robin pointer 0; capture stage invalid.
- Reset mid-operation: pending ready pulses are dropped and buffer contents are discarded.
- Arbitration (state ACC):
  - Each cycle, eligible = MACMUX_Val & ~MUXMAC_Rdy.
  - Pick the first eligible lane at or after the pointer (wrapping).
  - Register the winner's one-hot into MUXMAC_Rdy for the next cycle, so the pulse is exactly 1 cycle wide.
  - In the same edge, capture the winner's addr/psum into the capture stage and advance the pointer to winner+1 mod NUM_MAC.
  - Throughput: one accept per cycle.
  - Val-to-Rdy latency: 1 cycle with no contention.
- Accumulate:
  - One cycle after capture, buf[addr-1] <= buf[addr-1] + psum, as a wrap-around PSUM_WIDTH add with no saturation.
  - Captures with addr==0 or addr>DEPTH are accepted (Rdy still pulses) but discarded.
  - The buffer is a register array; read and write happen in the same cycle, so back-to-back hits on the same entry need no forwarding.
- State ACC→DRAIN when all of the following hold in the same cycle:
  - I_Flush = 1;
  - MACMUX_Empty is all ones;
  - MACMUX_Val is all zeros;
  - the capture stage is invalid.
- DRAIN:
  - No arbitration; MUXMAC_Rdy = 0.
  - O_Val = 1, O_Addr = idx, O_Psum = buf[idx], with idx starting at 0.
  - On O_Val & I_Rdy: buf[idx] <= 0 and idx advances by 1.
  - The beat with idx==DEPTH-1 accepted goes to state DONE.
  - O_Val stays high and O_Psum stable while I_Rdy is low.
- DONE: O_Done = 1 for one cycle, idx <= 0, then back to ACC.
- If MACMUX_Val rises during DRAIN, it is held off (no Rdy) until ACC resumes.

Decomposition:
- Shared package/include holds the PSUM_WIDTH, PSUM_ADDR_WIDTH and DEPTH defaults from the dw params header, plus the state encodings ACC=0, DRAIN=1, DONE=2.
- One natural sub-module: rr_arbiter (NUM_MAC request vector in, one-hot grant out, rotating pointer, update enable).

Test Plan:
- Single lane 0: Val with addr=3, psum=+100 → Rdy[0] one cycle later, width 1; buf[2]=100 two cycles after Val.
- All 3 lanes Val in the same cycle, addr=5, psums 10, -4, 7 → Rdy pulses 0,1,2 on consecutive cycles; buf[4]=13.
- Back-to-back same entry: lane 1 addr=1 psum=5, then lane 2 addr=1 psum=6 one cycle later → buf[0]=11, no lost update.
- Out-of-range: addr=0 and addr=15 → Rdy still pulses; all buf entries unchanged.
- Flush with lane 2 Empty=0 → stays in ACC. Lane 2 Empty→1 → O_Val rises next cycle with O_Addr=0. With I_Rdy toggled 1/0, all 14 entries stream in order and match expected sums; O_Done pulses once; subsequent readback is all zero.
- Wrap: 0x7FFFFF + 1 at PSUM_WIDTH=24 → 0x800000.
- Assert rst_n low during DRAIN at idx=6 → all outputs 0 and state ACC on release.
